// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - Button, tick, digit-flag and strobe bundle between controller and digit bank
interface time_set_ctrl_if;
    logic       sec_tick;
    logic       btn_mode;
    logic       btn_up;
    logic       min_U_hit9;
    logic       min_T_hit5;
    logic       hr_U_hit9;
    logic       hr_U_hit3;
    logic       hr_U_hit2;
    logic       hr_U_hit1;
    logic       hr_T_hit2;
    logic       hr_T_hit1;
    logic       min_U_inc;
    logic       min_T_inc;
    logic       hr_U_inc;
    logic       hr_T_inc;
    logic       min_T_set;
    logic       hr_U_set;
    logic       hr_T_set;
    logic [3:0] min_T_val;
    logic [3:0] hr_U_val;
    logic [3:0] hr_T_val;
    logic [1:0] mode;
    logic       blink;
    logic       pm;

    modport master (
        input  sec_tick, btn_mode, btn_up,
        input  min_U_hit9, min_T_hit5,
        input  hr_U_hit9, hr_U_hit3, hr_U_hit2, hr_U_hit1, hr_T_hit2, hr_T_hit1,
        output min_U_inc, min_T_inc, hr_U_inc, hr_T_inc,
        output min_T_set, hr_U_set, hr_T_set,
        output min_T_val, hr_U_val, hr_T_val,
        output mode, blink, pm
    );

    modport slave (
        output sec_tick, btn_mode, btn_up,
        output min_U_hit9, min_T_hit5,
        output hr_U_hit9, hr_U_hit3, hr_U_hit2, hr_U_hit1, hr_T_hit2, hr_T_hit1,
        input  min_U_inc, min_T_inc, hr_U_inc, hr_T_inc,
        input  min_T_set, hr_U_set, hr_T_set,
        input  min_T_val, hr_U_val, hr_T_val,
        input  mode, blink, pm
    );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - Alarm-clock time sequencer: tick counting, carries, wraps and set-mode FSM (optional HOUR12_EN)
module time_set_ctrl #(
    parameter int TICKS_PER_MIN = 60,
    parameter int SEC_W         = 6
) (
    input  logic           clk,
    input  logic           reset,
    time_set_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        INIT    = 2'd3
    } state_t;

    localparam logic [SEC_W-1:0] LAST_TICK = SEC_W'(TICKS_PER_MIN - 1);

    state_t            state, state_next;
    logic [SEC_W-1:0]  cnt, cnt_next;
    logic              blink, blink_next;
    logic              min_adv;
    logic              min_carry;
    logic              hr_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            blink <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            blink <= blink_next;
        end
    end

    // A mode button always wins over btn_up in the set modes; the RUN-mode
    // minute advance is independent of the button and still fires.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        blink_next = blink;
        min_adv    = 1'b0;
        min_carry  = 1'b0;
        case (state)
            INIT: state_next = RUN;
            RUN: begin
                blink_next = 1'b0;
                if (bus.sec_tick) begin
                    if (cnt == LAST_TICK) begin
                        cnt_next  = '0;
                        min_adv   = 1'b1;
                        min_carry = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                if (bus.btn_mode) state_next = SET_HR;
            end
            SET_HR: begin
                if (bus.btn_mode) begin
                    state_next = SET_MIN;
                    blink_next = 1'b0;
                end else if (bus.sec_tick) begin
                    blink_next = ~blink;
                end
            end
            SET_MIN: begin
                if (bus.btn_mode) begin
                    state_next = RUN;
                    blink_next = 1'b0;
                    cnt_next   = '0;
                end else begin
                    if (bus.btn_up)   min_adv    = 1'b1;
                    if (bus.sec_tick) blink_next = ~blink;
                end
            end
            default: state_next = INIT;
        endcase
    end

`ifdef HOUR12_EN
    logic pm_q;
    logic pm_toggle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pm_q <= 1'b0;
        else       pm_q <= pm_q ^ pm_toggle;
    end

    assign bus.pm = pm_q;

    logic unused_flags;
    assign unused_flags = ^{bus.hr_T_hit2, bus.hr_U_hit3};
`else
    assign bus.pm = 1'b0;

    logic unused_flags;
    assign unused_flags = ^{bus.hr_U_hit2, bus.hr_U_hit1, bus.hr_T_hit1};
`endif

    always_comb begin
        bus.min_U_inc = 1'b0;
        bus.min_T_inc = 1'b0;
        bus.hr_U_inc  = 1'b0;
        bus.hr_T_inc  = 1'b0;
        bus.min_T_set = 1'b0;
        bus.hr_U_set  = 1'b0;
        bus.hr_T_set  = 1'b0;
        bus.min_T_val = 4'd0;
        bus.hr_U_val  = 4'd0;
        bus.hr_T_val  = 4'd0;
        hr_adv        = (state == SET_HR) && bus.btn_up && !bus.btn_mode;
`ifdef HOUR12_EN
        pm_toggle     = 1'b0;
`endif

        if (min_adv) begin
            bus.min_U_inc = 1'b1;
            if (bus.min_U_hit9) begin
                if (bus.min_T_hit5) begin
                    bus.min_T_set = 1'b1;
                    hr_adv        = hr_adv | min_carry;
                end else begin
                    bus.min_T_inc = 1'b1;
                end
            end
        end

        if (hr_adv) begin
`ifdef HOUR12_EN
            if (bus.hr_T_hit1 && bus.hr_U_hit2) begin
                bus.hr_U_set = 1'b1;
                bus.hr_U_val = 4'd1;
                bus.hr_T_set = 1'b1;
                bus.hr_T_val = 4'd0;
            end else if (bus.hr_T_hit1 && bus.hr_U_hit1) begin
                bus.hr_U_inc = 1'b1;
                pm_toggle    = 1'b1;
            end else begin
                bus.hr_U_inc = 1'b1;
                bus.hr_T_inc = bus.hr_U_hit9;
            end
`else
            if (bus.hr_T_hit2 && bus.hr_U_hit3) begin
                bus.hr_U_set = 1'b1;
                bus.hr_T_set = 1'b1;
            end else begin
                bus.hr_U_inc = 1'b1;
                bus.hr_T_inc = bus.hr_U_hit9;
            end
`endif
        end

`ifdef HOUR12_EN
        // The 12h display powers up reading 12
        if (state == INIT) begin
            bus.hr_U_set = 1'b1;
            bus.hr_U_val = 4'd2;
            bus.hr_T_set = 1'b1;
            bus.hr_T_val = 4'd1;
        end
`endif

        // Strobes must drop the moment reset asserts, not at the next edge
        if (reset) begin
            bus.min_U_inc = 1'b0;
            bus.min_T_inc = 1'b0;
            bus.hr_U_inc  = 1'b0;
            bus.hr_T_inc  = 1'b0;
            bus.min_T_set = 1'b0;
            bus.hr_U_set  = 1'b0;
            bus.hr_T_set  = 1'b0;
            bus.min_T_val = 4'd0;
            bus.hr_U_val  = 4'd0;
            bus.hr_T_val  = 4'd0;
            hr_adv        = 1'b0;
`ifdef HOUR12_EN
            pm_toggle     = 1'b0;
`endif
        end
    end

    assign bus.mode  = (state == INIT) ? 2'd0 : state;
    assign bus.blink = blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - Directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    time_set_ctrl_if bus();

    time_set_ctrl #(.TICKS_PER_MIN(60), .SEC_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.sec_tick   = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.btn_up     = 1'b0;
        bus.min_U_hit9 = 1'b0;
        bus.min_T_hit5 = 1'b0;
        bus.hr_U_hit9  = 1'b0;
        bus.hr_U_hit3  = 1'b0;
        bus.hr_U_hit2  = 1'b0;
        bus.hr_U_hit1  = 1'b0;
        bus.hr_T_hit2  = 1'b0;
        bus.hr_T_hit1  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            bus.sec_tick = 1'b1;
            #2;
            if (bus.min_U_inc === 1'b1) seen++;
            step();
        end
        bus.sec_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #2;
        compared++; if (bus.mode !== 2'd0) begin mismatched++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
        compared++; if (bus.blink !== 1'b0) begin mismatched++; $display("FAIL reset_blink: got %b want 0", bus.blink); end
        compared++; if (bus.pm !== 1'b0) begin mismatched++; $display("FAIL reset_pm: got %b want 0", bus.pm); end
        compared++; if ({bus.min_U_inc, bus.min_T_inc, bus.hr_U_inc, bus.hr_T_inc, bus.min_T_set, bus.hr_U_set, bus.hr_T_set} !== 7'b0)
            begin mismatched++; $display("FAIL reset_strobes: got some strobe high want all 0"); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
`ifdef HOUR12_EN
        compared++; if (bus.hr_U_set !== 1'b1 || bus.hr_U_val !== 4'd2) begin mismatched++; $display("FAIL init_hr_U_load: got set=%b val=%0d want set=1 val=2", bus.hr_U_set, bus.hr_U_val); end
        compared++; if (bus.hr_T_set !== 1'b1 || bus.hr_T_val !== 4'd1) begin mismatched++; $display("FAIL init_hr_T_load: got set=%b val=%0d want set=1 val=1", bus.hr_T_set, bus.hr_T_val); end
`else
        compared++; if (bus.hr_U_set !== 1'b0 || bus.hr_T_set !== 1'b0) begin mismatched++; $display("FAIL init_no_load: got hr_U_set=%b hr_T_set=%b want 0 0", bus.hr_U_set, bus.hr_T_set); end
`endif
        compared++; if (bus.mode !== 2'd0) begin mismatched++; $display("FAIL init_mode: got %0d want 0", bus.mode); end
        step();
    endtask

    task automatic test_min_carry();
        int seen;
        run_ticks(59, seen);
        compared++; if (seen !== 0) begin mismatched++; $display("FAIL carry_pre59: got %0d strobes want 0", seen); end
        bus.sec_tick = 1'b1; bus.min_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1) begin mismatched++; $display("FAIL carry_min_U_inc: got %b want 1", bus.min_U_inc); end
        compared++; if (bus.min_T_inc !== 1'b1) begin mismatched++; $display("FAIL carry_min_T_inc: got %b want 1", bus.min_T_inc); end
        compared++; if (bus.min_T_set !== 1'b0 || bus.hr_U_inc !== 1'b0) begin mismatched++; $display("FAIL carry_extra: got min_T_set=%b hr_U_inc=%b want 0 0", bus.min_T_set, bus.hr_U_inc); end
        step();
        clear_inputs();
    endtask

    task automatic test_hour_wrap();
        int seen;
        logic exp_set, exp_inc;
`ifdef HOUR12_EN
        exp_set = 1'b0; exp_inc = 1'b1;
`else
        exp_set = 1'b1; exp_inc = 1'b0;
`endif
        run_ticks(59, seen);
        bus.sec_tick = 1'b1; bus.min_U_hit9 = 1'b1; bus.min_T_hit5 = 1'b1; bus.hr_T_hit2 = 1'b1; bus.hr_U_hit3 = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1 || bus.min_T_inc !== 1'b0) begin mismatched++; $display("FAIL wrap_min_inc: got U=%b T=%b want 1 0", bus.min_U_inc, bus.min_T_inc); end
        compared++; if (bus.min_T_set !== 1'b1 || bus.min_T_val !== 4'd0) begin mismatched++; $display("FAIL wrap_min_T_set: got set=%b val=%0d want 1 0", bus.min_T_set, bus.min_T_val); end
        compared++; if (bus.hr_U_set !== exp_set || bus.hr_T_set !== exp_set) begin mismatched++; $display("FAIL wrap_hr_set: got U=%b T=%b want %b", bus.hr_U_set, bus.hr_T_set, exp_set); end
        compared++; if (bus.hr_U_inc !== exp_inc || bus.hr_T_inc !== 1'b0) begin mismatched++; $display("FAIL wrap_hr_inc: got U=%b T=%b want %b 0", bus.hr_U_inc, bus.hr_T_inc, exp_inc); end
        step();
        clear_inputs();
        run_ticks(59, seen);
        bus.sec_tick = 1'b1; bus.min_U_hit9 = 1'b1; bus.min_T_hit5 = 1'b1; bus.hr_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.hr_U_inc !== 1'b1 || bus.hr_T_inc !== 1'b1 || bus.hr_U_set !== 1'b0) begin mismatched++; $display("FAIL carry_09_59: got U_inc=%b T_inc=%b U_set=%b want 1 1 0", bus.hr_U_inc, bus.hr_T_inc, bus.hr_U_set); end
        step();
        clear_inputs();
    endtask

    task automatic test_set_hr();
        int seen;
        run_ticks(10, seen);
        bus.btn_mode = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b0) begin mismatched++; $display("FAIL sethr_enter_strobe: got %b want 0", bus.min_U_inc); end
        step();
        clear_inputs();
        compared++; if (bus.mode !== 2'd1 || bus.blink !== 1'b0) begin mismatched++; $display("FAIL sethr_mode: got mode=%0d blink=%b want 1 0", bus.mode, bus.blink); end
        bus.btn_up = 1'b1; bus.hr_U_hit9 = 1'b1; bus.min_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.hr_U_inc !== 1'b1 || bus.hr_T_inc !== 1'b1) begin mismatched++; $display("FAIL sethr_09_up: got U=%b T=%b want 1 1", bus.hr_U_inc, bus.hr_T_inc); end
        compared++; if (bus.min_U_inc !== 1'b0) begin mismatched++; $display("FAIL sethr_no_min: got %b want 0", bus.min_U_inc); end
        step();
        clear_inputs();
        bus.btn_up = 1'b1; bus.hr_T_hit2 = 1'b1; bus.hr_U_hit3 = 1'b1;
        #2;
`ifdef HOUR12_EN
        compared++; if (bus.hr_U_inc !== 1'b1 || bus.hr_U_set !== 1'b0) begin mismatched++; $display("FAIL sethr_23_up: got inc=%b set=%b want 1 0", bus.hr_U_inc, bus.hr_U_set); end
`else
        compared++; if (bus.hr_U_inc !== 1'b0 || bus.hr_U_set !== 1'b1 || bus.hr_T_set !== 1'b1) begin mismatched++; $display("FAIL sethr_23_up: got inc=%b Uset=%b Tset=%b want 0 1 1", bus.hr_U_inc, bus.hr_U_set, bus.hr_T_set); end
`endif
        step();
        clear_inputs();
        bus.sec_tick = 1'b1; bus.min_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b0 || bus.hr_U_inc !== 1'b0) begin mismatched++; $display("FAIL sethr_tick_strobe: got min=%b hr=%b want 0 0", bus.min_U_inc, bus.hr_U_inc); end
        step();
        clear_inputs();
        compared++; if (bus.blink !== 1'b1) begin mismatched++; $display("FAIL sethr_blink: got %b want 1", bus.blink); end
    endtask

    task automatic test_set_min();
        int seen;
        bus.btn_mode = 1'b1;
        step();
        clear_inputs();
        compared++; if (bus.mode !== 2'd2 || bus.blink !== 1'b0) begin mismatched++; $display("FAIL setmin_mode: got mode=%0d blink=%b want 2 0", bus.mode, bus.blink); end
        bus.btn_up = 1'b1; bus.min_U_hit9 = 1'b1; bus.min_T_hit5 = 1'b1; bus.hr_T_hit2 = 1'b1; bus.hr_U_hit3 = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1 || bus.min_T_set !== 1'b1 || bus.min_T_val !== 4'd0 || bus.min_T_inc !== 1'b0) begin mismatched++; $display("FAIL setmin_59_up: got Uinc=%b Tset=%b val=%0d Tinc=%b want 1 1 0 0", bus.min_U_inc, bus.min_T_set, bus.min_T_val, bus.min_T_inc); end
        compared++; if ({bus.hr_U_inc, bus.hr_T_inc, bus.hr_U_set, bus.hr_T_set} !== 4'b0) begin mismatched++; $display("FAIL setmin_no_hour: got %b want 0000", {bus.hr_U_inc, bus.hr_T_inc, bus.hr_U_set, bus.hr_T_set}); end
        step();
        clear_inputs();
        bus.btn_up = 1'b1; bus.min_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.min_T_inc !== 1'b1 || bus.min_T_set !== 1'b0) begin mismatched++; $display("FAIL setmin_09_up: got Tinc=%b Tset=%b want 1 0", bus.min_T_inc, bus.min_T_set); end
        step();
        clear_inputs();
        bus.sec_tick = 1'b1;
        step();
        clear_inputs();
        compared++; if (bus.blink !== 1'b1) begin mismatched++; $display("FAIL setmin_blink: got %b want 1", bus.blink); end
        bus.btn_mode = 1'b1; bus.btn_up = 1'b1; bus.min_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b0 || bus.min_T_inc !== 1'b0) begin mismatched++; $display("FAIL modeup_drop: got Uinc=%b Tinc=%b want 0 0", bus.min_U_inc, bus.min_T_inc); end
        step();
        clear_inputs();
        compared++; if (bus.mode !== 2'd0 || bus.blink !== 1'b0) begin mismatched++; $display("FAIL modeup_run: got mode=%0d blink=%b want 0 0", bus.mode, bus.blink); end
        run_ticks(59, seen);
        compared++; if (seen !== 0) begin mismatched++; $display("FAIL count_cleared: got %0d early strobes want 0", seen); end
        bus.sec_tick = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1) begin mismatched++; $display("FAIL count_60th: got %b want 1", bus.min_U_inc); end
        step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int seen;
        run_ticks(59, seen);
        bus.sec_tick = 1'b1; bus.btn_mode = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1) begin mismatched++; $display("FAIL tick_mode_adv: got %b want 1", bus.min_U_inc); end
        step();
        clear_inputs();
        compared++; if (bus.mode !== 2'd1) begin mismatched++; $display("FAIL tick_mode_state: got %0d want 1", bus.mode); end
        bus.btn_mode = 1'b1;
        step();
        step();
        clear_inputs();
        compared++; if (bus.mode !== 2'd0) begin mismatched++; $display("FAIL mode_cycle_run: got %0d want 0", bus.mode); end
        bus.btn_up = 1'b1; bus.hr_U_hit9 = 1'b1; bus.min_U_hit9 = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b0 || bus.hr_U_inc !== 1'b0) begin mismatched++; $display("FAIL run_up_ignored: got min=%b hr=%b want 0 0", bus.min_U_inc, bus.hr_U_inc); end
        step();
        clear_inputs();
    endtask

    task automatic test_hour12();
        int seen;
        logic exp_pm;
`ifdef HOUR12_EN
        exp_pm = 1'b1;
`else
        exp_pm = 1'b0;
`endif
        run_ticks(59, seen);
        bus.sec_tick = 1'b1; bus.min_U_hit9 = 1'b1; bus.min_T_hit5 = 1'b1; bus.hr_T_hit1 = 1'b1; bus.hr_U_hit1 = 1'b1;
        #2;
        compared++; if (bus.hr_U_inc !== 1'b1 || bus.hr_T_inc !== 1'b0 || bus.hr_U_set !== 1'b0) begin mismatched++; $display("FAIL h11_carry: got Uinc=%b Tinc=%b Uset=%b want 1 0 0", bus.hr_U_inc, bus.hr_T_inc, bus.hr_U_set); end
        step();
        clear_inputs();
        compared++; if (bus.pm !== exp_pm) begin mismatched++; $display("FAIL h11_pm: got %b want %b", bus.pm, exp_pm); end
`ifdef HOUR12_EN
        run_ticks(59, seen);
        bus.sec_tick = 1'b1; bus.min_U_hit9 = 1'b1; bus.min_T_hit5 = 1'b1; bus.hr_T_hit1 = 1'b1; bus.hr_U_hit2 = 1'b1;
        #2;
        compared++; if (bus.hr_U_set !== 1'b1 || bus.hr_U_val !== 4'd1 || bus.hr_T_set !== 1'b1 || bus.hr_T_val !== 4'd0) begin mismatched++; $display("FAIL h12_wrap: got Uset=%b Uval=%0d Tset=%b Tval=%0d want 1 1 1 0", bus.hr_U_set, bus.hr_U_val, bus.hr_T_set, bus.hr_T_val); end
        compared++; if (bus.hr_U_inc !== 1'b0) begin mismatched++; $display("FAIL h12_no_inc: got %b want 0", bus.hr_U_inc); end
        step();
        clear_inputs();
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        run_ticks(59, seen);
        bus.sec_tick = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1) begin mismatched++; $display("FAIL mid_pre_strobe: got %b want 1", bus.min_U_inc); end
        reset = 1'b1;
        #1;
        compared++; if (bus.min_U_inc !== 1'b0) begin mismatched++; $display("FAIL mid_reset_strobe: got %b want 0", bus.min_U_inc); end
        clear_inputs();
        @(posedge clk);
        #1;
        compared++; if (bus.pm !== 1'b0) begin mismatched++; $display("FAIL mid_reset_pm: got %b want 0", bus.pm); end
        reset = 1'b0;
        step();
        run_ticks(59, seen);
        compared++; if (seen !== 0) begin mismatched++; $display("FAIL mid_restart_early: got %0d strobes want 0", seen); end
        bus.sec_tick = 1'b1;
        #2;
        compared++; if (bus.min_U_inc !== 1'b1) begin mismatched++; $display("FAIL mid_restart_60th: got %b want 1", bus.min_U_inc); end
        step();
        clear_inputs();
        bus.btn_mode = 1'b1;
        step();
        clear_inputs();
        bus.sec_tick = 1'b1;
        step();
        clear_inputs();
        reset = 1'b1;
        #1;
        compared++; if (bus.mode !== 2'd0 || bus.blink !== 1'b0) begin mismatched++; $display("FAIL mid_sethr_reset: got mode=%0d blink=%b want 0 0", bus.mode, bus.blink); end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_min_carry();
        test_hour_wrap();
        test_set_hr();
        test_set_min();
        test_back_to_back();
        test_hour12();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Sequencing controller for the alarm-clock time datapath: drives inc/set/value strobes into the four BCD digit registers (min_U, min_T, hr_U, hr_T). Counts sec_tick pulses to advance time, cascades carries and forces 59→00 and 23→00 wraps. Runs the mode FSM for setting hours and minutes by button. Sits between the debounced button and prescaler logic and the digit register bank.

Parameters:
TICKS_PER_MIN, 60, number of sec_tick pulses per minute advance (≥2)
SEC_W, 6, width of the internal seconds counter (must hold TICKS_PER_MIN-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sec_tick  in  1  single-cycle 1 Hz pulse
btn_mode  in  1  debounced single-cycle pulse: cycle mode
btn_up  in  1  debounced single-cycle pulse: increment selected field
min_U_hit9, min_T_hit5  in  1  digit flags from minute registers
hr_U_hit9, hr_U_hit3, hr_U_hit2, hr_U_hit1  in  1  hour-units flags
hr_T_hit2, hr_T_hit1  in  1  hour-tens flags
min_U_inc, min_T_inc, hr_U_inc, hr_T_inc  out  1  increment strobes
min_T_set, hr_U_set, hr_T_set  out  1  load strobes
min_T_val, hr_U_val, hr_T_val  out  4  load values, valid with matching set
mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN
blink  out  1  display blink phase for the field being set
pm  out  1  PM indicator (HOUR12_EN only)

Behaviour:
- States: INIT, RUN, SET_HR, SET_MIN. Reset → INIT. All strobes 0, val buses 0, sec count 0, blink 0, pm 0, mode 0 during reset.
- INIT lasts one cycle, then RUN. No loads in 24h build.
- All strobes are combinational from state, count and inputs. Each strobe is high for exactly one cycle per event.
- set and inc are never asserted to the same register in the same cycle.
- RUN: sec_tick increments sec count. At count TICKS_PER_MIN-1 a tick clears it to 0 and fires a minute advance in that same cycle.
- Minute advance:
  - min_U_inc=1.
  - If min_U_hit9: min_T_inc=1, unless min_T_hit5, in which case min_T_set=1 with min_T_val=0 and an hour advance fires.
- Hour advance (24h):
  - If hr_T_hit2 && hr_U_hit3: hr_U_set=hr_T_set=1 with both vals 0.
  - Otherwise hr_U_inc=1, plus hr_T_inc=1 if hr_U_hit9.
- SET_HR: btn_up performs an hour advance only.
- SET_MIN: btn_up performs the minute advance without the hour carry; 59→00 stays in the same hour.
- sec_tick does not advance time in set modes.
- btn_mode: RUN→SET_HR→SET_MIN→RUN. Leaving SET_MIN clears sec count to 0.
- Simultaneous btn_mode and btn_up: mode change wins; btn_up is dropped.
- Simultaneous btn_mode and a minute-advance tick in RUN: the advance is issued, and the state is SET_HR next cycle.
- blink: toggles on each sec_tick in SET_HR/SET_MIN. Forced 0 in RUN and on every mode change.
- mode output equals the state encoding; INIT reports 0.
- Reset mid-operation: asynchronous return to INIT with all outputs at their reset values, including the strobes.

Optional Feature:
HOUR12_EN
- Defined:
  - INIT issues hr_U_set/hr_T_set with vals 2/1, so the display starts at 12.
  - Hour advance:
    - 12→01: hr_U_set val 1 and hr_T_set val 0 (condition hr_T_hit1 && hr_U_hit2).
    - 11→12: hr_U_inc and pm toggles (condition hr_T_hit1 && hr_U_hit1).
    - Otherwise as in 24h, without the 23 wrap.
  - SET_HR button advances also toggle pm at 11→12.
- Undefined: 24h behaviour as above; pm tied 0; hr_U_hit2, hr_U_hit1 and hr_T_hit1 are ignored.

Test Plan:
- Reset asserted mid-RUN with sec count at 30 → all strobes 0 immediately; after release, INIT then RUN; count restarts from 0 (60 ticks to the next min_U_inc).
- RUN, 59 ticks then a 60th with min_U_hit9=1 and min_T_hit5=0 → min_U_inc=1 and min_T_inc=1 in the same cycle; no min_T_set.
- RUN at 23:59 (min_U_hit9, min_T_hit5, hr_T_hit2, hr_U_hit3), 60th tick → min_U_inc=1, min_T_set val 0, hr_U_set and hr_T_set val 0; no hr inc.
- btn_mode ×1 then btn_up at 09 (hr_U_hit9) → mode=1, hr_U_inc=1, hr_T_inc=1; sec_tick pulses cause no strobes and toggle blink.
- mode=2 at minute 59 with btn_up → min_U_inc, min_T_set val 0, no hour strobes. btn_mode+btn_up in the same cycle → mode=0, no strobes, sec count 0.
- HOUR12_EN: after reset, hr_U_set val 2 and hr_T_set val 1. At 11 (hr_T_hit1, hr_U_hit1) a minute carry gives hr_U_inc and pm 0→1. At 12 a carry gives hr_U_set val 1 and hr_T_set val 0.
